bcd2_scan_counter: RTL and testbench
====================================

Name: bcd2_scan_counter

Overview:
- Two-digit BCD up/down counter (00–99) with an internal count prescaler and a display-scan toggle generator.
- Sits directly upstream of the two-digit SSD digit selector.
- digit1 feeds the selector's `a` input (tens); digit0 feeds `b` (ones); scan_en drives its `enable`.
- All outputs are registered; one clock domain.

Parameters:
- TICK_DIV, default 100000000: clk cycles per count step (1 Hz at 100 MHz); legal range ≥ 2.
- SCAN_DIV, default 100000: clk cycles per scan_en half-period; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- count_en  input  1  1 = prescaler runs and counting is enabled; 0 = pause, all count state held.
- dir  input  1  1 = count up, 0 = count down; sampled only at the tick edge.
- clr  input  1  synchronous clear of count state only.
- digit1  output  4  tens digit, BCD 0–9.
- digit0  output  4  ones digit, BCD 0–9.
- scan_en  output  1  digit-select toggle; 1 = tens digit selected downstream.
- tick  output  1  one-cycle pulse, asserted in the cycle the digits take a new value.
- carry  output  1  one-cycle pulse on wrap, 99→00 going up or 00→99 going down.

Behaviour:
- Reset values (rst=1 at an edge):
  - digit1=0, digit0=0, tick=0, carry=0, scan_en=1.
  - Prescaler counter and scan counter = 0.
  - Reset applies mid-operation with no residue of previous state.
- Priority at each edge: rst > clr > count tick.
- Prescaler (tick_cnt):
  - Width is clog2(TICK_DIV).
  - If count_en=1 and tick_cnt<TICK_DIV-1: tick_cnt += 1, tick <= 0.
  - If count_en=1 and tick_cnt==TICK_DIV-1: tick_cnt <= 0, digits step once, tick <= 1.
  - If count_en=0: tick_cnt and digits hold, tick <= 0, carry <= 0. Resuming continues from the held tick_cnt.
  - Result: with count_en held at 1, tick pulses once every TICK_DIV cycles, coincident with the new digit values.
- Step up (dir=1):
  - If digit0<9: digit0 += 1.
  - Otherwise digit0 <= 0 and, if digit1<9, digit1 += 1.
  - At 99: go to 00 and carry <= 1.
- Step down (dir=0):
  - If digit0>0: digit0 -= 1.
  - Otherwise digit0 <= 9 and, if digit1>0, digit1 -= 1.
  - At 00: go to 99 and carry <= 1.
- carry is 0 in every cycle other than a wrapping tick cycle; when asserted it is always coincident with tick=1.
- dir changes between ticks have no effect until the next tick edge.
- Digit values outside 0–9 are unreachable: the only state sources are reset, clr and the step rules.
- clr=1 at an edge:
  - digits <= 00, tick_cnt <= 0, tick <= 0, carry <= 0.
  - A tick due at the same edge is discarded.
  - The scan logic is unaffected.
- Scan generator:
  - scan_cnt (width clog2(SCAN_DIV), minimum 1 bit) runs freely, independent of count_en and clr.
  - When scan_cnt==SCAN_DIV-1: scan_cnt <= 0 and scan_en <= ~scan_en. Otherwise scan_cnt += 1.
  - scan_en period = 2*SCAN_DIV cycles, 50% duty.
  - With SCAN_DIV=1, scan_en toggles every cycle.
- No combinational path from any input to any output.

Test Plan:
All scenarios use TICK_DIV=4 and SCAN_DIV=3.
1. Reset and first step:
   - rst=1 for 2 cycles → digits 00, scan_en=1, tick=0, carry=0.
   - Release with count_en=1, dir=1 → tick=1 and digit0=1 on the 4th edge after release; next tick 4 edges later, digit0=2.
2. Ones wrap up: count up from 08 → 09 → 10 on successive ticks, carry=0 throughout; digit1 changes only on the 09→10 tick.
3. Full wrap:
   - Up from 99 → 00 with carry=1 and tick=1 in the same single cycle.
   - dir=0 from 00 → 99 with carry=1.
   - 10 down → 09, carry=0.
4. Pause:
   - Drop count_en when tick_cnt=2 and hold for 10 cycles → digits, tick_cnt hold; tick and carry stay 0.
   - Re-raise count_en → tick arrives on the 2nd edge after resume.
5. clr collisions:
   - clr=1 on the same edge a tick is due, digits 57 → digits 00, tick=0; the next tick comes TICK_DIV cycles later.
   - clr=1 together with rst=1 → reset values.
6. Scan independence: scan_en toggles every 3 cycles (1,1,1,0,0,0,…) after reset, unchanged across count_en toggling and clr pulses; verify period 6 over ≥ 4 periods.

Source files
------------

// File: rtl/bcd2_scan_counter.sv
// ---------------------------------------------------------------------------
// bcd2_scan_counter
//
// Two-digit BCD up/down counter (00-99) with a built-in count prescaler and a
// free-running display-scan toggle generator. It feeds the two-digit SSD digit
// selector: digit1 goes to the selector's tens input, digit0 to its ones
// input, and scan_en drives its enable.
//
// Parameters:
//   TICK_DIV  clk cycles per count step (>= 2)
//   SCAN_DIV  clk cycles per scan_en half-period (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   count_en  1 = prescaler runs and counting is enabled, 0 = hold count state
//   dir       1 = count up, 0 = count down (only sampled at a tick edge)
//   clr       synchronous clear of the count state (scan logic untouched)
//   digit1    tens digit, BCD
//   digit0    ones digit, BCD
//   scan_en   digit-select toggle, 1 = tens digit selected downstream
//   tick      one-cycle pulse in the cycle the digits take a new value
//   carry     one-cycle pulse on a 99->00 or 00->99 wrap, always with tick
//
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module bcd2_scan_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       count_en,
    input  logic       dir,
    input  logic       clr,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       scan_en,
    output logic       tick,
    output logic       carry
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [3:0]    step_d1;
    logic [3:0]    step_d0;
    logic          step_wrap;

    // Work out what the digits would become if a count step happened right
    // now in the current direction. The register block only uses this on the
    // prescaler's terminal cycle, so dir has no effect between ticks.
    // step_wrap flags the 99->00 / 00->99 rollover that produces carry.
    always_comb begin
        step_d1   = digit1;
        step_d0   = digit0;
        step_wrap = 1'b0;
        if (dir) begin
            if (digit0 < 4'd9) begin
                step_d0 = digit0 + 4'd1;
            end else begin
                step_d0 = 4'd0;
                if (digit1 < 4'd9) begin
                    step_d1 = digit1 + 4'd1;
                end else begin
                    step_d1   = 4'd0;
                    step_wrap = 1'b1;
                end
            end
        end else begin
            if (digit0 > 4'd0) begin
                step_d0 = digit0 - 4'd1;
            end else begin
                step_d0 = 4'd9;
                if (digit1 > 4'd0) begin
                    step_d1 = digit1 - 4'd1;
                end else begin
                    step_d1   = 4'd9;
                    step_wrap = 1'b1;
                end
            end
        end
    end

    // Count path: prescaler plus the two BCD digits. Reset beats clear, and
    // clear beats a tick due on the same edge, so a colliding tick is simply
    // dropped and the prescaler restarts from zero. While count_en is low
    // the prescaler and digits freeze where they are, so resuming picks up
    // the partially elapsed tick period instead of starting over. tick and
    // carry are rewritten every cycle so they can only ever last one cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tick_cnt <= '0;
            digit1   <= 4'd0;
            digit0   <= 4'd0;
            tick     <= 1'b0;
            carry    <= 1'b0;
        end else if (count_en) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                digit1   <= step_d1;
                digit0   <= step_d0;
                tick     <= 1'b1;
                carry    <= step_wrap;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
                tick     <= 1'b0;
                carry    <= 1'b0;
            end
        end else begin
            tick  <= 1'b0;
            carry <= 1'b0;
        end
    end

    // Scan generator: free-running, ignores count_en and clr so the display
    // keeps multiplexing even while the count is paused or being cleared.
    // scan_en flips every SCAN_DIV cycles, giving a 50% duty square wave.
    // With SCAN_DIV = 1 the counter is a single bit pinned at zero and
    // scan_en toggles on every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_en  <= 1'b1;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_en  <= ~scan_en;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_bcd2_scan_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd2_scan_counter
//
// Self-checking bench for bcd2_scan_counter with TICK_DIV = 4, SCAN_DIV = 3.
// A short cycle-by-cycle vector table covers reset and the first two steps;
// hand-written sequences then cover digit rollover, full wrap in both
// directions, pause/resume, clear collisions and scan independence.
// The expected count is tracked as a plain integer 0..99.
// ---------------------------------------------------------------------------
module tb_bcd2_scan_counter;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       count_en;
    logic       dir;
    logic       clr;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       scan_en;
    logic       tick;
    logic       carry;

    int compared   = 0;
    int mismatched = 0;
    int model_val  = 0;

    typedef struct {
        logic rst;
        logic clr;
        logic ce;
        logic dir;
        int   val;
        logic tk;
        logic cy;
        logic sc;
    } vec_t;

    vec_t vecs[10];

    // Free-running 100 MHz-style clock, 10 time units per period.
    always #5 clk = ~clk;

    bcd2_scan_counter #(
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .count_en(count_en),
        .dir     (dir),
        .clr     (clr),
        .digit1  (digit1),
        .digit0  (digit0),
        .scan_en (scan_en),
        .tick    (tick),
        .carry   (carry)
    );

    // Drive one cycle of inputs, let a rising edge take them, and return 1
    // time unit after that edge so outputs are sampled well clear of it.
    task automatic applyStimulus(input logic r, input logic c, input logic ce, input logic d);
        rst      = r;
        clr      = c;
        count_en = ce;
        dir      = d;
        @(posedge clk);
        #1;
    endtask

    // Compare digits, tick and carry against the expected count value.
    task automatic checkOutput(input string name, input int exp_val,
                               input logic exp_tick, input logic exp_carry);
        logic [3:0] e1;
        logic [3:0] e0;
        e1 = 4'(exp_val / 10);
        e0 = 4'(exp_val % 10);
        compared++;
        if (digit1 !== e1 || digit0 !== e0 || tick !== exp_tick || carry !== exp_carry) begin
            mismatched++;
            $display("[TB] FAIL %s: got digits=%0d%0d tick=%b carry=%b, want digits=%0d%0d tick=%b carry=%b",
                     name, digit1, digit0, tick, carry, e1, e0, exp_tick, exp_carry);
        end
    endtask

    task automatic checkScan(input string name, input logic exp_scan);
        compared++;
        if (scan_en !== exp_scan) begin
            mismatched++;
            $display("[TB] FAIL %s: got scan_en=%b, want %b", name, scan_en, exp_scan);
        end
    endtask

    // Run n full tick periods with count_en high. dir is driven to the
    // opposite direction on the non-tick cycles to show it is ignored there.
    task automatic runTicks(input string name, input int n, input logic d);
        logic wrap;
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < TICK_DIV - 1; c++) begin
                applyStimulus(1'b0, 1'b0, 1'b1, ~d);
                checkOutput({name, " between ticks"}, model_val, 1'b0, 1'b0);
            end
            wrap      = d ? (model_val == 99) : (model_val == 0);
            model_val = d ? (model_val + 1) % 100 : (model_val + 99) % 100;
            applyStimulus(1'b0, 1'b0, 1'b1, d);
            checkOutput({name, " tick"}, model_val, 1'b1, wrap);
        end
    endtask

    initial begin
        $display("[TB] starting bcd2_scan_counter bench");

        // Reset for two cycles, then count up: first tick on the 4th edge
        // after release, second 4 edges later. scan_en: 1,1,1,0,0,0,1,...
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].ce, vecs[i].dir);
            checkOutput($sformatf("vector %0d", i), vecs[i].val, vecs[i].tk, vecs[i].cy);
            checkScan($sformatf("vector %0d scan", i), vecs[i].sc);
        end
        model_val = 2;

        // Ones rollover going up: 02 -> 08, then 09 and 10 with no carry.
        runTicks("up to 10", 8, 1'b1);

        // Full wrap up 99 -> 00, wrap down 00 -> 99, then down through 10 -> 09.
        runTicks("up to 00", 90, 1'b1);
        runTicks("down to 99", 1, 1'b0);
        runTicks("down to 09", 90, 1'b0);

        // Pause with the prescaler at 2 for 10 cycles, then resume: the
        // held count means the tick lands on the 2nd edge after resume.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pre-pause 1", model_val, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pre-pause 2", model_val, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("paused %0d", i), model_val, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("resume edge 1", model_val, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        model_val = 8;
        checkOutput("resume edge 2 tick", model_val, 1'b1, 1'b0);

        // Count up to 57, then clear on the very edge the next tick is due.
        runTicks("up to 57", 49, 1'b1);
        for (int i = 0; i < TICK_DIV - 1; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput("before clr", 57, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        model_val = 0;
        checkOutput("clr beats tick", model_val, 1'b0, 1'b0);
        runTicks("after clr", 1, 1'b1);

        // Reset together with clear, mid tick-period with nonzero digits.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        model_val = 0;
        checkOutput("rst with clr", model_val, 1'b0, 1'b0);
        checkScan("rst with clr scan", 1'b1);
        runTicks("after rst", 1, 1'b1);

        // Scan independence: fresh reset, then 36 cycles with count_en
        // toggling and clr pulses; scan_en must follow 1,1,1,0,0,0 exactly.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkScan("scan reset", 1'b1);
        for (int i = 0; i < 36; i++) begin
            applyStimulus(1'b0, (i % 7) == 3, (i % 5) < 3, 1'b1);
            checkScan($sformatf("scan cycle %0d", i + 1), (((i + 1) / SCAN_DIV) % 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
